// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling at a fixed tick count per bit.
// Optional macro UART_RX_MAJORITY_EN: each sample is the 2-of-3 majority of the last three rx_s values.
module uart_rx_oversampled #(
  parameter int TICKS_PER_BIT      = 32,
  parameter int TICKS_PER_BIT_SIZE = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_din,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int W = TICKS_PER_BIT_SIZE;
  localparam logic [W-1:0] TLAST = W'(TICKS_PER_BIT - 1);
  localparam logic [W-1:0] HLAST = W'(TICKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] TONE  = W'(1);

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    START     = 5'b00010,
    DATA      = 5'b00100,
    STOP      = 5'b01000,
    WAIT_HIGH = 5'b10000
  } state_t;

  state_t       state_q;
  logic [W-1:0] tick_q;
  logic [3:0]   bitcnt_q;
  logic [7:0]   shift_q;
  logic [7:0]   data_q;
  logic         valid_q;
  logic         ferr_q;
  logic         sync1_q;
  logic         sync2_q;
  logic         rx_s;
  logic         sample_d;

  assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is rx_s one cycle back, hist_q[1] two cycles back
  logic [1:0] hist_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rx_s};
  end

  assign sample_d = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample_d = rx_s;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
    end else begin
      sync1_q <= i_din;
      sync2_q <= sync1_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            tick_q  <= '0;
          end
        end
        START: begin
          if (tick_q == HLAST) begin
            if (!sample_d) begin
              state_q  <= DATA;
              tick_q   <= '0;
              bitcnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            tick_q <= tick_q + TONE;
          end
        end
        DATA: begin
          if (tick_q == TLAST) begin
            tick_q   <= '0;
            shift_q  <= {sample_d, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) state_q <= STOP;
          end else begin
            tick_q <= tick_q + TONE;
          end
        end
        STOP: begin
          if (tick_q == TLAST) begin
            tick_q <= '0;
            data_q <= shift_q;
            // leave mid-stop-bit so a back-to-back start edge is not missed
            if (sample_d) begin
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            tick_q <= tick_q + TONE;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Randomised bench for uart_rx_oversampled: frames driven bit by bit, strobes compared with predicted events.
module tb_uart_rx_oversampled;
  localparam int T   = 32;
  localparam int H   = T / 2;
  localparam int LAT = 2 + H + 9 * T + 1;

  logic       gclk = 1'b0;
  logic       rst  = 1'b1;
  logic       din  = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_busy;

  uart_rx_oversampled #(.TICKS_PER_BIT(T), .TICKS_PER_BIT_SIZE(6)) dut (
    .i_clk(gclk), .i_rst(rst), .i_din(din),
    .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 gclk = ~gclk;

  int cyc = 0;
  always @(posedge gclk) cyc <= cyc + 1;

  typedef struct {int c; bit ferr; logic [7:0] d;} ev_t;
  ev_t exp_q[$];
  ev_t act_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, expv);
    end
  endtask

  // strobe monitor, sampled on the falling edge
  always @(negedge gclk) begin
    if (!rst && (o_valid || o_frame_err)) begin
      chk("strobe_excl", {31'd0, o_valid & o_frame_err}, 32'd0);
      act_q.push_back('{cyc, o_frame_err, o_data});
    end
  end

  task automatic step(input bit v);
    din = v;
    @(posedge gclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  // Drives one 10-bit frame; glitch_idx inverts one line cycle, rst_idx aborts with a 1-cycle reset.
  task automatic send_frame(input logic [7:0] d, input bit stop, input logic [7:0] exp_d,
                            input int glitch_idx, input int rst_idx);
    int  c0;
    bit  v;
    c0 = cyc;
    for (int i = 0; i < 10 * T; i++) begin
      if (i < T)          v = 1'b0;
      else if (i < 9 * T) v = d[i / T - 1];
      else                v = stop;
      if (i == glitch_idx) v = ~v;
      if (i == rst_idx) begin
        rst = 1'b1;
        step(v);
        rst = 1'b0;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_data", {24'd0, o_data}, 32'd0);
        din = 1'b1;
        return;
      end
      step(v);
    end
    exp_q.push_back('{c0 + LAT, !stop, exp_d});
  endtask

  initial begin
    int busy_cnt;
    logic [7:0] glitch_exp;
    ev_t a, e;

    repeat (3) @(posedge gclk);
    #1;
    chk("reset_data",  {24'd0, o_data}, 32'd0);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_ferr",  {31'd0, o_frame_err}, 32'd0);
    chk("reset_busy",  {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    idle(10);

    send_frame(8'hA5, 1'b1, 8'hA5, -1, -1);
    chk("idle_busy_a5", {31'd0, o_busy}, 32'd0);
    idle(20);

    // back-to-back, no idle between stop and next start
    send_frame(8'h00, 1'b1, 8'h00, -1, -1);
    send_frame(8'hFF, 1'b1, 8'hFF, -1, -1);
    idle(20);

    // short low glitch: false start, busy for exactly H cycles
    busy_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      step(i >= 5);
      if (o_busy) busy_cnt++;
    end
    chk("glitch_busy_cycles", busy_cnt, H);

    // framing error then line held low
    send_frame(8'h3C, 1'b0, 8'h3C, -1, -1);
    for (int i = 0; i < 200; i++) step(1'b0);
    chk("wait_high_busy", {31'd0, o_busy}, 32'd1);
    idle(10);
    chk("after_break_busy", {31'd0, o_busy}, 32'd0);
    send_frame(8'h5A, 1'b1, 8'h5A, -1, -1);
    idle(20);

    // reset during data bit 4
    send_frame(8'h77, 1'b1, 8'h77, -1, 5 * T + 10);
    idle(30);
    send_frame(8'h81, 1'b1, 8'h81, -1, -1);
    idle(20);

    // one-cycle glitch exactly at the bit-2 sample point
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hF0;
`else
    glitch_exp = 8'hF4;
`endif
    send_frame(8'hF0, 1'b1, glitch_exp, H + 3 * T, -1);
    idle(20);

    for (int f = 0; f < 30; f++) begin
      logic [7:0] d;
      bit         stop;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      send_frame(d, stop, d, -1, -1);
      if (!stop) begin
        for (int i = 0; i < int'($urandom_range(0, 50)); i++) step(1'b0);
        idle(2 + int'($urandom_range(0, 10)));
      end else begin
        idle(int'($urandom_range(0, 20)));
      end
    end

    idle(400);
    chk("event_count", act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk("ev_cycle", a.c, e.c);
      chk("ev_ferr", {31'd0, a.ferr}, {31'd0, e.ferr});
      chk("ev_data", {24'd0, a.d}, {24'd0, e.d});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
